// File: rtl/multicycle_adder_pkg.sv
// multicycle_adder shared types and helpers.
// Digit count and counter sizing derived from WIDTH/DIGIT.
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int digits(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multicycle_adder_digit.sv
// digit_adder: combinational DIGIT-wide ripple of full adders.
// One instance forms the whole carry chain of the serial adder.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: digit-serial add/subtract, LSB digit first.
// Start/busy/done handshake; results registered on entry to DONE.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N  = digits(WIDTH, DIGIT);
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad
    $error("multicycle_adder: WIDTH must be a multiple of DIGIT");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic            c_q, c_d;
  logic            am_q, am_d;
  logic            bm_q, bm_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic [WIDTH-1:0] a_nx;
  logic [WIDTH-1:0] b_nx;
  logic [WIDTH-1:0] bx;

  digit_adder #(.DIGIT(DIGIT)) u_dig (
    .a  (a_q[DIGIT-1:0]),
    .b  (b_q[DIGIT-1:0]),
    .ci (c_q),
    .s  (dsum),
    .co (dco)
  );

  // A register doubles as result register: sum digits enter at the MSB
  if (DIGIT == WIDTH) begin : g_one
    assign a_nx = dsum;
    assign b_nx = '0;
  end else begin : g_shift
    assign a_nx = {dsum, a_q[WIDTH-1:DIGIT]};
    assign b_nx = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    am_d    = am_q;
    bm_d    = bm_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    bx      = sub ? ~B : B;

    unique case (state_q)
      RUN: begin
        a_d   = a_nx;
        b_d   = b_nx;
        c_d   = dco;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          s_d     = a_nx;
          cout_d  = dco;
          ovf_d   = (am_q == bm_q) && (a_nx[WIDTH-1] != am_q);
        end
      end
      IDLE, DONE: state_d = start ? RUN : IDLE;
      default:    state_d = IDLE;
    endcase

    if (start && (state_q != RUN)) begin
      a_d   = A;
      b_d   = bx;
      c_d   = sub ^ Cin;
      cnt_d = '0;
      am_d  = A[WIDTH-1];
      bm_d  = bx[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      am_q    <= am_d;
      bm_q    <= bm_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: DIGIT=4, 1 and 16 builds side by side.
// Results compared against an integer-arithmetic reference model.
module tb_multicycle_adder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  st;
  logic        sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  busy_w;
  logic [2:0]  done_w;
  logic [15:0] s_w [3];
  logic [2:0]  co_w;
  logic [2:0]  ov_w;

  int n_chk;
  int n_err;

  multicycle_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sub), .Cin(cin),
    .A(a), .B(b), .busy(busy_w[0]), .done(done_w[0]), .S(s_w[0]),
    .Cout(co_w[0]), .Ovf(ov_w[0])
  );

  multicycle_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sub), .Cin(cin),
    .A(a), .B(b), .busy(busy_w[1]), .done(done_w[1]), .S(s_w[1]),
    .Cout(co_w[1]), .Ovf(ov_w[1])
  );

  multicycle_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sub), .Cin(cin),
    .A(a), .B(b), .busy(busy_w[2]), .done(done_w[2]), .S(s_w[2]),
    .Cout(co_w[2]), .Ovf(ov_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {ovf, cout, s}: plain integer arithmetic on the operands
  function automatic logic [17:0] model(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic sb, input logic ci);
    int sx, sy, r;
    logic [16:0] u;
    logic co, ov;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!sb) begin
      u  = {1'b0, x} + {1'b0, y} + {16'b0, ci};
      co = u[16];
      r  = sx + sy + int'(ci);
    end else begin
      u  = {1'b0, x} - {1'b0, y} - {16'b0, ci};
      co = ({1'b0, x} >= ({1'b0, y} + {16'b0, ci}));
      r  = sx - sy - int'(ci);
    end
    ov = (r > 32767) || (r < -32768);
    return {ov, co, u[15:0]};
  endfunction

  function automatic int exp_lat(input int i);
    return (i == 0) ? 5 : ((i == 1) ? 17 : 2);
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    for (int t = 1; t <= 40 && lat == 0; t++) begin
      tick();
      st = '0;
      if (done_w[0]) lat = t;
    end
  endtask

  task automatic run_all(input logic [15:0] x, input logic [15:0] y,
                         input logic sb, input logic ci);
    logic [17:0] m;
    int lat [3];
    int nd [3];
    logic [15:0] sv [3];
    logic cv [3];
    logic ovv [3];
    int nb;
    m = model(x, y, sb, ci);
    a = x; b = y; sub = sb; cin = ci;
    st = 3'b111;
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0; nd[i] = 0; sv[i] = '0; cv[i] = 1'b0; ovv[i] = 1'b0;
    end
    for (int t = 1; t <= 20; t++) begin
      tick();
      st = '0;
      if (busy_w[0]) nb++;
      for (int i = 0; i < 3; i++) begin
        if (done_w[i]) begin
          nd[i]++;
          if (lat[i] == 0) begin
            lat[i] = t; sv[i] = s_w[i]; cv[i] = co_w[i]; ovv[i] = ov_w[i];
          end
        end
      end
    end
    chk("busy_cycles_d4", nb, 4);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lat[%0d]", i), lat[i], exp_lat(i));
      chk($sformatf("done_pulses[%0d]", i), nd[i], 1);
      chk($sformatf("S[%0d] %h%s%h", i, x, sb ? "-" : "+", y), sv[i], m[15:0]);
      chk($sformatf("Cout[%0d]", i), cv[i], m[16]);
      chk($sformatf("Ovf[%0d]", i), ovv[i], m[17]);
      chk($sformatf("S_held[%0d]", i), s_w[i], m[15:0]);
    end
  endtask

  initial begin
    int lat;
    int nd;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; st = '0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    tick(); tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset[%0d]", i),
          {busy_w[i], done_w[i], s_w[i], co_w[i], ov_w[i]}, 0);
    rst_n = 1'b1;
    tick();

    run_all(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    run_all(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_all(16'h7FFF, 16'h0000, 1'b0, 1'b1);
    run_all(16'h0005, 16'h0007, 1'b1, 1'b0);
    run_all(16'h8000, 16'h0001, 1'b1, 1'b0);
    chk("spec_ovf_sub", {ov_w[0], co_w[0], s_w[0]}, {2'b11, 16'h7FFF});

    // start mid-RUN must be dropped, not queued
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0;
    st = 3'b001;
    tick(); st = '0;
    tick();
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
    st = 3'b001;
    tick(); st = '0;
    wait_done(lat);
    chk("midrun_lat", lat, 2);
    chk("midrun_S", s_w[0], 16'h3333);
    nd = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (done_w[0] || busy_w[0]) nd++;
    end
    chk("midrun_noqueue", nd, 0);

    // back-to-back: second start in the DONE cycle
    a = 16'h00F0; b = 16'h0F0F; sub = 1'b0; cin = 1'b1;
    st = 3'b001;
    wait_done(lat);
    chk("b2b_lat1", lat, 5);
    chk("b2b_S1", s_w[0], 16'h1000);
    a = 16'h1234; b = 16'h0034; sub = 1'b1; cin = 1'b0;
    st = 3'b001;
    wait_done(lat);
    chk("b2b_lat2", lat, 5);
    chk("b2b_S2", {co_w[0], s_w[0]}, {1'b1, 16'h1200});

    // asynchronous reset in the middle of RUN
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b0;
    st = 3'b001;
    tick(); st = '0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {busy_w[0], done_w[0], s_w[0], co_w[0], ov_w[0]}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_idle", {busy_w[0], done_w[0]}, 0);
    run_all(16'h4321, 16'h1111, 1'b1, 1'b1);

    for (int k = 0; k < 30; k++)
      run_all(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
